// File: rtl/pipe_skid_stage_if.sv
// Valid/ready beat channel between pipeline stages: control bits plus payload.
// master drives the beat, slave returns ready.
interface pipe_skid_stage_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a 2-entry skid buffer; 1-cycle latency, 1 beat/cycle.
// in_ready decodes registered state only, so out_ready never reaches it combinationally.
module pipe_skid_stage #(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 8,
  parameter int FLUSH_DATA = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_skid_stage_if.slave  in_if,
  pipe_skid_stage_if.master out_if,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              in_xfer, out_xfer;
  logic              load_main_in, load_main_skid, load_skid;

  assign in_if.ready  = (state_q != FULL);
  assign out_if.valid = (state_q != EMPTY);
  assign out_if.ctrl  = out_if.valid ? main_ctrl : '0;
  assign out_if.data  = main_data;
  assign occupancy    = state_q;

  assign in_xfer  = in_if.valid & in_if.ready;
  assign out_xfer = out_if.valid & out_if.ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over every transition; an accepted incoming beat is dropped.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_data <= '0;
      skid_data <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        main_ctrl <= '0;
        skid_ctrl <= '0;
        if (FLUSH_DATA != 0) begin
          main_data <= '0;
          skid_data <= '0;
        end
      end else begin
        if (load_main_in) begin
          main_ctrl <= in_if.ctrl;
          main_data <= in_if.data;
        end else if (load_main_skid) begin
          main_ctrl <= skid_ctrl;
          main_data <= skid_data;
        end
        if (load_skid) begin
          skid_ctrl <= in_if.ctrl;
          skid_data <= in_if.data;
        end
      end
    end
  end

  // Performance counter: survives flush, saturates rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_if.valid && !out_if.ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomised checks of pipe_skid_stage; two instances share stimulus:
// dut_a keeps payload on flush with a 16-bit counter, dut_b zeroes payload with a 4-bit counter.
module tb_pipe_skid_stage;
  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic [1:0]  occ_a, occ_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int checks   = 0;
  int failures = 0;

  pipe_skid_stage_if #(.CTRL_W(CW), .DATA_W(DW)) a_in ();
  pipe_skid_stage_if #(.CTRL_W(CW), .DATA_W(DW)) a_out ();
  pipe_skid_stage_if #(.CTRL_W(CW), .DATA_W(DW)) b_in ();
  pipe_skid_stage_if #(.CTRL_W(CW), .DATA_W(DW)) b_out ();

  assign a_in.valid  = in_valid;
  assign a_in.ctrl   = in_ctrl;
  assign a_in.data   = in_data;
  assign a_out.ready = out_ready;
  assign b_in.valid  = in_valid;
  assign b_in.ctrl   = in_ctrl;
  assign b_in.data   = in_data;
  assign b_out.ready = out_ready;

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_DATA(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_if(a_in), .out_if(a_out),
    .occupancy(occ_a), .stall_cnt(cnt_a));

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_DATA(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_if(b_in), .out_if(b_out),
    .occupancy(occ_b), .stall_cnt(cnt_b));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    #12;
    checks++; if (a_out.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_out.valid); end
    checks++; if (a_out.ctrl !== 8'h00) begin failures++; $display("FAIL reset_ctrl got=%h exp=00", a_out.ctrl); end
    checks++; if (a_in.ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", a_in.ready); end
    checks++; if (occ_a !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occ_a); end
    checks++; if (cnt_a !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", cnt_a); end
    checks++; if (a_out.data !== 16'h0 || b_out.data !== 16'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0000", a_out.data, b_out.data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'h01, DW'(i));
      checks++; if (a_in.ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready beat=%0d got=%b exp=1", i, a_in.ready); end
      step();
      checks++; if (a_out.valid !== 1'b1 || a_out.data !== DW'(i)) begin failures++; $display("FAIL stream_out beat=%0d got=%b/%h exp=1/%h", i, a_out.valid, a_out.data, i); end
      checks++; if (occ_a !== 2'd1) begin failures++; $display("FAIL stream_occ beat=%0d got=%0d exp=1", i, occ_a); end
    end
    drive(1'b0, '0, '0);
    step();
    checks++; if (a_out.valid !== 1'b0 || occ_a !== 2'd0) begin failures++; $display("FAIL stream_drain got=%b/%0d exp=0/0", a_out.valid, occ_a); end
    checks++; if (cnt_a !== 16'd0) begin failures++; $display("FAIL stream_stall got=%0d exp=0", cnt_a); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 16'h00A0);
    step();
    checks++; if (occ_a !== 2'd1 || a_in.ready !== 1'b1) begin failures++; $display("FAIL bp_after_a got=%0d/%b exp=1/1", occ_a, a_in.ready); end
    drive(1'b1, 8'h22, 16'h00B0);
    step();
    checks++; if (occ_a !== 2'd2 || a_in.ready !== 1'b0) begin failures++; $display("FAIL bp_after_b got=%0d/%b exp=2/0", occ_a, a_in.ready); end
    checks++; if (a_out.data !== 16'h00A0 || a_out.ctrl !== 8'h11) begin failures++; $display("FAIL bp_head got=%h/%h exp=00a0/11", a_out.data, a_out.ctrl); end
    drive(1'b1, 8'h33, 16'h00C0);
    step();
    step();
    checks++; if (occ_a !== 2'd2 || a_out.data !== 16'h00A0) begin failures++; $display("FAIL bp_hold got=%0d/%h exp=2/00a0", occ_a, a_out.data); end
    out_ready = 1'b1;
    step();
    checks++; if (a_out.data !== 16'h00B0 || occ_a !== 2'd1 || a_in.ready !== 1'b1) begin failures++; $display("FAIL bp_rel_b got=%h/%0d/%b exp=00b0/1/1", a_out.data, occ_a, a_in.ready); end
    step();
    checks++; if (a_out.data !== 16'h00C0 || a_out.ctrl !== 8'h33 || occ_a !== 2'd1) begin failures++; $display("FAIL bp_rel_c got=%h/%h/%0d exp=00c0/33/1", a_out.data, a_out.ctrl, occ_a); end
    drive(1'b0, '0, '0);
    step();
    checks++; if (occ_a !== 2'd0) begin failures++; $display("FAIL bp_empty got=%0d exp=0", occ_a); end
    checks++; if (cnt_a !== 16'd3 || cnt_b !== 4'd3) begin failures++; $display("FAIL bp_stall got=%0d/%0d exp=3/3", cnt_a, cnt_b); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 8'h44, 16'h00D0);
    step();
    drive(1'b1, 8'h55, 16'h00E0);
    step();
    checks++; if (occ_a !== 2'd2) begin failures++; $display("FAIL flush_setup got=%0d exp=2", occ_a); end
    drive(1'b1, 8'h66, 16'h00F0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    checks++; if (a_out.valid !== 1'b0 || a_out.ctrl !== 8'h00 || occ_a !== 2'd0) begin failures++; $display("FAIL flush_a got=%b/%h/%0d exp=0/00/0", a_out.valid, a_out.ctrl, occ_a); end
    checks++; if (b_out.valid !== 1'b0 || b_out.ctrl !== 8'h00 || occ_b !== 2'd0) begin failures++; $display("FAIL flush_b got=%b/%h/%0d exp=0/00/0", b_out.valid, b_out.ctrl, occ_b); end
    checks++; if (a_out.data !== 16'h00D0) begin failures++; $display("FAIL flush_keep_data got=%h exp=00d0", a_out.data); end
    checks++; if (b_out.data !== 16'h0000) begin failures++; $display("FAIL flush_zero_data got=%h exp=0000", b_out.data); end
    checks++; if (a_in.ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", a_in.ready); end
    step();
    checks++; if (a_out.valid !== 1'b0 || occ_a !== 2'd0) begin failures++; $display("FAIL flush_no_beat got=%b/%0d exp=0/0", a_out.valid, occ_a); end
    checks++; if (cnt_a !== 16'd5 || cnt_b !== 4'd5) begin failures++; $display("FAIL flush_stall got=%0d/%0d exp=5/5", cnt_a, cnt_b); end
  endtask

  task automatic test_saturate();
    out_ready = 1'b0;
    drive(1'b1, 8'h77, 16'h0123);
    step();
    drive(1'b0, '0, '0);
    repeat (20) step();
    checks++; if (cnt_b !== 4'd15) begin failures++; $display("FAIL sat_b got=%0d exp=15", cnt_b); end
    checks++; if (cnt_a !== 16'd25) begin failures++; $display("FAIL sat_a got=%0d exp=25", cnt_a); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (cnt_b !== 4'd15 || cnt_a !== 16'd26) begin failures++; $display("FAIL sat_flush got=%0d/%0d exp=15/26", cnt_b, cnt_a); end
    step();
    checks++; if (cnt_a !== 16'd26 || a_out.valid !== 1'b0) begin failures++; $display("FAIL sat_idle got=%0d/%b exp=26/0", cnt_a, a_out.valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 16'h0AAA);
    step();
    drive(1'b1, 8'h02, 16'h0BBB);
    step();
    checks++; if (occ_a !== 2'd2) begin failures++; $display("FAIL rmid_setup got=%0d exp=2", occ_a); end
    #2 rst = 1'b1;
    #1;
    checks++; if (a_out.valid !== 1'b0 || a_out.ctrl !== 8'h00 || a_in.ready !== 1'b1) begin failures++; $display("FAIL rmid_hs got=%b/%h/%b exp=0/00/1", a_out.valid, a_out.ctrl, a_in.ready); end
    checks++; if (occ_a !== 2'd0 || cnt_a !== 16'd0 || cnt_b !== 4'd0) begin failures++; $display("FAIL rmid_cnt got=%0d/%0d/%0d exp=0/0/0", occ_a, cnt_a, cnt_b); end
    checks++; if (a_out.data !== 16'h0 || b_out.data !== 16'h0) begin failures++; $display("FAIL rmid_data got=%h/%h exp=0000", a_out.data, b_out.data); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 8'h09, 16'h0777);
    step();
    checks++; if (a_out.data !== 16'h0777 || a_out.ctrl !== 8'h09 || occ_a !== 2'd1) begin failures++; $display("FAIL rmid_first got=%h/%h/%0d exp=0777/09/1", a_out.data, a_out.ctrl, occ_a); end
    drive(1'b0, '0, '0);
    step();
  endtask

  task automatic test_random();
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_d;
    logic          ir;
    int            seq = 1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      drive(1'($urandom_range(0, 1)), seq[7:0] | 8'h01, seq[DW-1:0]);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      ir = a_in.ready;
      out_ready = ~out_ready;
      #1;
      if (a_in.ready !== ir) begin
        checks++; failures++;
        $display("FAIL rand_ready_path cyc=%0d got=%b exp=%b", cyc, a_in.ready, ir);
      end
      out_ready = ~out_ready;
      #1;
      if (in_valid && a_in.ready) begin
        sb.push_back(seq[DW-1:0]);
        seq++;
      end
      if (a_out.valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rand_dup cyc=%0d got=%h exp=none", cyc, a_out.data);
        end else begin
          exp_d = sb.pop_front();
          if (a_out.data !== exp_d || b_out.data !== exp_d || a_out.ctrl !== (exp_d[7:0] | 8'h01)) begin
            failures++;
            $display("FAIL rand_order cyc=%0d got=%h/%h/%h exp=%h", cyc, a_out.data, b_out.data, a_out.ctrl, exp_d);
          end
        end
      end
      step();
    end
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    for (int k = 0; k < 4 && a_out.valid; k++) begin
      checks++;
      exp_d = (sb.size() != 0) ? sb.pop_front() : '0;
      if (a_out.data !== exp_d) begin failures++; $display("FAIL rand_drain got=%h exp=%h", a_out.data, exp_d); end
      step();
    end
    checks++; if (a_out.valid !== 1'b0 || sb.size() != 0) begin failures++; $display("FAIL rand_end got=%b/%0d exp=0/0", a_out.valid, sb.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
